// File: rtl/audio_pkg.sv
// Shared audio definitions: default widths and the sample-pair type used by
// both the DAC transmitter and the ADC receiver.
`timescale 1ns/1ps
package audio_pkg;

    localparam int AUDIO_DATA_W      = 16;
    localparam int AUDIO_SYNC_STAGES = 2;

    typedef struct packed {
        logic [AUDIO_DATA_W-1:0] left;
        logic [AUDIO_DATA_W-1:0] right;
    } sample_pair_t;

endpackage

// File: rtl/audio_clk_sync.sv
// N-stage synchronizer for a codec clock. Provides the synchronized level
// and single-cycle rise/fall pulses derived from synchronized values only.
`timescale 1ns/1ps
module audio_clk_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Synchronizer chain plus one history flop for edge detection
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/audio_dac_tx.sv
// I2S transmitter toward a master-mode codec. One sample pair is buffered in
// a holding register, handed to the frame registers at each left boundary,
// and each channel is shifted out MSB first after a one-BCLK delay slot.
`timescale 1ns/1ps
module audio_dac_tx
    import audio_pkg::*;
#(
    parameter int DATA_W      = AUDIO_DATA_W,
    parameter int SYNC_STAGES = AUDIO_SYNC_STAGES
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              audio_interface_BCLK,
    input  logic              audio_interface_DACLRCK,
    output logic              audio_interface_DACDAT,
    input  logic [DATA_W-1:0] sample_left,
    input  logic [DATA_W-1:0] sample_right,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic              underrun
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic bclk_level_unused, bclk_rise_unused, bfall;
    logic lrck, lrck_rise_unused, lrck_fall_unused;

    audio_clk_sync #(.STAGES(SYNC_STAGES)) u_bclk_sync (
        .clk_i  (clk_clk),
        .rst_ni (reset_reset_n),
        .async_i(audio_interface_BCLK),
        .level_o(bclk_level_unused),
        .rise_o (bclk_rise_unused),
        .fall_o (bfall)
    );

    audio_clk_sync #(.STAGES(SYNC_STAGES)) u_lrck_sync (
        .clk_i  (clk_clk),
        .rst_ni (reset_reset_n),
        .async_i(audio_interface_DACLRCK),
        .level_o(lrck),
        .rise_o (lrck_rise_unused),
        .fall_o (lrck_fall_unused)
    );

    logic [DATA_W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
    logic              hold_full_q, hold_full_d;
    logic [DATA_W-1:0] frame_l_q, frame_l_d, frame_r_q, frame_r_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              dacdat_q, dacdat_d;
    logic              underrun_q, underrun_d;
    logic              prev_lrck_q, prev_lrck_d;
    logic              seen_left_q, seen_left_d;

    logic              hs, left_bnd, right_bnd;
    logic [DATA_W-1:0] next_l, next_r;

    // Boundaries compare LRCK at this bfall against LRCK at the previous bfall
    assign left_bnd  = bfall & ~lrck &  prev_lrck_q;
    assign right_bnd = bfall &  lrck & ~prev_lrck_q;
    assign hs        = sample_valid & ~hold_full_q;
    // An empty holding register at a left boundary sends silence
    assign next_l    = hold_full_q ? hold_l_q : '0;
    assign next_r    = hold_full_q ? hold_r_q : '0;

    // Next-state: holding register, frame hand-off and serializer
    always_comb begin
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        hold_full_d = hs | (hold_full_q & ~left_bnd);
        frame_l_d   = frame_l_q;
        frame_r_d   = frame_r_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        dacdat_d    = dacdat_q;
        underrun_d  = 1'b0;
        prev_lrck_d = prev_lrck_q;
        seen_left_d = seen_left_q;

        if (hs) begin
            hold_l_d = sample_left;
            hold_r_d = sample_right;
        end
        if (bfall) prev_lrck_d = lrck;

        if (left_bnd) begin
            // Old pair (q values) goes to the frames even if a new one lands now
            frame_l_d   = next_l;
            frame_r_d   = next_r;
            underrun_d  = ~hold_full_q;
            seen_left_d = 1'b1;
            shift_d     = next_l;
            cnt_d       = CNT_W'(DATA_W);
            dacdat_d    = 1'b0;
        end else if (right_bnd) begin
            // Before the first left boundary there is no valid right word
            shift_d  = seen_left_q ? frame_r_q : '0;
            cnt_d    = CNT_W'(DATA_W);
            dacdat_d = 1'b0;
        end else if (bfall) begin
            if (cnt_q != '0) begin
                dacdat_d = shift_q[DATA_W-1];
                shift_d  = shift_q << 1;
                cnt_d    = cnt_q - CNT_W'(1);
            end else begin
                dacdat_d = 1'b0;
            end
        end
    end

    // State registers
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            hold_full_q <= 1'b0;
            frame_l_q   <= '0;
            frame_r_q   <= '0;
            shift_q     <= '0;
            cnt_q       <= '0;
            dacdat_q    <= 1'b0;
            underrun_q  <= 1'b0;
            prev_lrck_q <= 1'b0;
            seen_left_q <= 1'b0;
        end else begin
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
            hold_full_q <= hold_full_d;
            frame_l_q   <= frame_l_d;
            frame_r_q   <= frame_r_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            dacdat_q    <= dacdat_d;
            underrun_q  <= underrun_d;
            prev_lrck_q <= prev_lrck_d;
            seen_left_q <= seen_left_d;
        end
    end

    assign audio_interface_DACDAT = dacdat_q;
    assign underrun               = underrun_q;
    assign sample_ready           = ~hold_full_q;

endmodule

// File: doc/audio_dac_tx.md
AUDIO_DAC_TX -- requirements
Module: audio_dac_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning sample width per channel in bits (legal 8..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer depth for codec clocks (legal 2..3).
REQ-003 SHALL have port clk_clk  input  1  system clock, rising edge, at least 8x BCLK frequency.
REQ-004 SHALL have port reset_reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port audio_interface_BCLK  input  1  codec bit clock (codec is master), asynchronous to clk_clk.
REQ-006 SHALL have port audio_interface_DACLRCK  input  1  codec DAC word clock: 0 = left, 1 = right, asynchronous.
REQ-007 SHALL have port audio_interface_DACDAT  output  1  serial I2S data to codec.
REQ-008 SHALL have port sample_left  input  DATA_W  left sample, two's complement.
REQ-009 SHALL have port sample_right  input  DATA_W  right sample, two's complement.
REQ-010 SHALL have port sample_valid  input  1  sample pair offered.
REQ-011 SHALL have port sample_ready  output  1  holding register can accept a pair.
REQ-012 SHALL have port underrun  output  1  one-cycle pulse when a frame starts with no sample.

Function
REQ-013 SHALL pass BCLK and DACLRCK through identical SYNC_STAGES flop chains; edge detection uses the synchronized values only.
REQ-014 SHALL act only on detected BCLK falling edges ("bfall"), sampling synchronized DACLRCK at the same cycle.
REQ-015 SHALL hold one pair in a holding register; transfer occurs when sample_valid and sample_ready are both 1 on a rising clk_clk edge.
REQ-016 SHALL drive sample_ready = 1 when the holding register is empty; the holding register is emptied only at a left boundary.
REQ-017 SHALL define a left boundary as a bfall where sampled LRCK = 0 and the LRCK sampled at the previous bfall = 1; a right boundary is the opposite transition.
REQ-018 SHALL, at a left boundary with the holding register full, copy both channels to frame registers and mark it empty, so sample_ready rises the next cycle.
REQ-019 SHALL, at a left boundary with the holding register empty, load zeros into both frame registers and pulse underrun for exactly one cycle.
REQ-020 SHALL, when a handshake and a left-boundary transfer occur in the same cycle, send the old pair to the frames and store the new pair in the holding register, with no loss.
REQ-021 SHALL, at each boundary, load the shift register with the frame register of the new channel and set the bit counter to DATA_W; DACDAT outputs 0 for that bit (the I2S one-BCLK delay slot).
REQ-022 SHALL, on each later bfall with counter > 0, drive DACDAT with the shift register MSB, shift left by 1, and decrement the counter.
REQ-023 SHALL drive DACDAT = 0 on every bfall with counter = 0, zero-padding channel slots longer than DATA_W.
REQ-024 SHALL register DACDAT on the bfall cycle, so DACDAT changes SYNC_STAGES+1 clk_clk cycles after the physical BCLK fall.
REQ-025 SHALL truncate the channel word and restart at the new MSB if a boundary arrives while counter > 0 (short slot).
REQ-026 SHALL output zeros for right channels until the first left boundary after reset has been seen.

Reset
REQ-027 SHALL, while reset_reset_n = 0, force DACDAT = 0, underrun = 0, sample_ready = 1, holding register empty, frame and shift registers = 0, counter = 0, synchronizers = 0, and previous-LRCK = 0.
REQ-028 SHALL, after reset deasserts mid-frame, stay silent (DACDAT = 0) until a left boundary, and never emit a partial word.

Structure
REQ-029 SHALL place the DATA_W default, the sample-pair typedef and the SYNC_STAGES default in shared package audio_pkg, which the receiver side also uses.
REQ-030 SHALL instantiate sub-module audio_clk_sync twice: an N-stage synchronizer that outputs the synced level plus rise and fall pulses.

Verification
REQ-031 SHALL cover: clk 50 MHz, BCLK 3.072 MHz, 32 BCLK per channel, pair L=0xA5C3, R=0x1234 -> DACDAT after the delay slot gives 1010010111000011, then 16 zeros, then 0001001000110100, then 16 zeros.
REQ-032 SHALL cover: no sample offered at a left boundary -> underrun high for 1 cycle, 64 zero bits, sample_ready stays 1.
REQ-033 SHALL cover: sample_valid asserted in the same cycle as the left-boundary transfer, pairs P1 then P2 -> P1 in frame N and P2 in frame N+1, with no underrun.
REQ-034 SHALL cover: reset asserted at bit 7 of the left word and released 3 BCLK later -> DACDAT 0 until the next left boundary, then a full correct word.
REQ-035 SHALL cover: 12 BCLK per channel with DATA_W=16 -> only the 11 MSBs are sent, and the next channel starts at its MSB after the delay slot.
REQ-036 SHALL cover: held sample_valid with back-to-back pairs over 100 frames -> every pair is serialized once in order, and sample_ready deasserts only while the holding register is full.
